// File: rtl/uart_reg_master.sv
// uart_reg_master: streams TX bytes into, and RX bytes out of, the memory-mapped
// UART divider/data register pair, replacing CPU polling.
// Optional build macro UART_REG_MASTER_DIV_CFG_EN adds a runtime divider-write port
// (cfg_div_valid/cfg_div_ready/cfg_div_data).
`timescale 1ns/1ps

module uart_reg_master #(
  parameter logic [31:0] DIV_INIT = 32'd104,
  parameter int          RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic [3:0]  reg_div_we,
  output logic [31:0] reg_div_di,
  output logic        reg_dat_we,
  output logic        reg_dat_re,
  output logic [31:0] reg_dat_di,
  input  logic [31:0] reg_dat_do,
  input  logic        reg_dat_wait
`ifdef UART_REG_MASTER_DIV_CFG_EN
  ,
  input  logic        cfg_div_valid,
  output logic        cfg_div_ready,
  input  logic [31:0] cfg_div_data
`endif
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RX_DEPTH);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              busy;
  logic [7:0]        tx_hold;
  logic              div_go, tx_go, rd_go;
  logic [31:0]       div_val;
  logic              tx_hs, cfg_hs, wr_done, push, pop;
  logic [7:0]        fifo_mem [RX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              unused_do_bits;

  assign unused_do_bits = ^reg_dat_do[31:9];

  // A new TX byte is only taken when idle and not in a divider-write cycle.
  assign tx_ready = (state == ST_RUN) && !busy && (reg_div_we == 4'h0);
  assign tx_hs    = tx_valid && tx_ready;
  assign wr_done  = reg_dat_we && !reg_dat_wait;

`ifdef UART_REG_MASTER_DIV_CFG_EN
  assign cfg_div_ready = (state == ST_RUN) && !busy && !reg_dat_we;
  assign cfg_hs        = cfg_div_valid && cfg_div_ready;
`else
  assign cfg_hs        = 1'b0;
`endif

  assign rx_valid = (fifo_cnt != '0);
  assign rx_data  = fifo_mem[rd_ptr];
  assign pop      = rx_valid && rx_ready;
  assign push     = reg_dat_re;

  // State register; reset always returns to INIT so the divider is reloaded.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // Next state plus the launch decisions for divider, data-write and data-read strobes.
  always_comb begin
    state_nxt = state;
    div_go    = 1'b0;
    div_val   = DIV_INIT;
    tx_go     = 1'b0;
    rd_go     = 1'b0;
    case (state)
      ST_INIT: begin
        state_nxt = ST_RUN;
        div_go    = 1'b1;
      end
      ST_RUN: begin
`ifdef UART_REG_MASTER_DIV_CFG_EN
        if (cfg_hs) begin
          div_go  = 1'b1;
          div_val = cfg_div_data;
        end
`endif
        // A byte accepted alongside a divider write is launched one cycle later.
        tx_go = (tx_hs && !cfg_hs) || (busy && !reg_dat_we);
        // One outstanding read at most, so the space check only needs this cycle's pop.
        rd_go = reg_dat_do[8] && !reg_dat_re && ((fifo_cnt < DEPTH_C) || pop);
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Registered bus strobes and the TX busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_div_we <= 4'h0;
      reg_div_di <= 32'h0;
      reg_dat_we <= 1'b0;
      reg_dat_di <= 32'h0;
      reg_dat_re <= 1'b0;
      busy       <= 1'b0;
    end else begin
      reg_div_we <= div_go ? 4'hF : 4'h0;
      if (div_go) reg_div_di <= div_val;
      reg_dat_re <= rd_go;
      if (wr_done) begin
        reg_dat_we <= 1'b0;
        busy       <= 1'b0;
      end else begin
        if (tx_go) begin
          reg_dat_we <= 1'b1;
          reg_dat_di <= {24'h0, (tx_hs ? tx_data : tx_hold)};
        end
        if (tx_hs) busy <= 1'b1;
      end
    end
  end

  // TX holding register (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (tx_hs) tx_hold <= tx_data;
  end

  // RX FIFO pointers and occupancy; a flush on reset discards queued bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // RX FIFO storage; the byte on the data register is captured during the read strobe.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= reg_dat_do[7:0];
  end

endmodule
